jtframe_btn_sense: RTL and testbench
====================================

Name: jtframe_btn_sense

Overview:
- Input-side counterpart of the frame LED driver: the LED block stretches short internal pulses into visible frame-long indications, this block filters noisy physical button levels into clean, frame-aligned internal events.
- Sits between the board button pins (MiST/MiSTer user buttons, cabinet service/test keys) and the game/framework logic.
- Per button: 2-FF synchroniser, frame-based debouncer, edge pulses, long-press detector.
- Time base is the vertical blank, the same way the LED block times its pulses.

Parameters:
- N, 2, number of independent buttons.
- DEB, 3, frames a new raw level must stay stable before it is accepted (1..15).
- LONG, 60, frames a debounced press must last before long-press is flagged (1..255).
- ACTIVE_LOW, 1, raw pin polarity; 1 means pressed = 0 on btn_raw.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  system clock
- LVBL  input  1  vertical blank, active-low; a falling edge marks a frame tick
- btn_raw  input  N  asynchronous raw button pins
- btn  output  N  debounced level, 1 = pressed
- press  output  N  one-clk pulse on debounced 0->1
- release  output  N  one-clk pulse on debounced 1->0
- long_press  output  N  level, high while held for at least LONG frames
- rpt  output  N  auto-repeat pulse (feature only, else tied 0)

Behaviour:
- Reset: all outputs 0, all debounce/hold counters 0, synchroniser flops held at the released level (not 0), last_LVBL 0.
- Synchroniser:
  - btn_raw passes through two flops, inverted when ACTIVE_LOW=1, giving sync[i] (1 = pressed).
  - Latency from pin to sync is 2 clk.
- Frame tick:
  - last_LVBL <= LVBL.
  - tick <= !LVBL && last_LVBL (registered, 1 clk wide).
  - No activity on tick while LVBL is held constant.
- Debounce, per bit, 4-bit counter dcnt, evaluated only on tick:
  - sync == btn: dcnt <= 0.
  - sync != btn and dcnt == DEB-1: btn <= sync, dcnt <= 0.
  - otherwise: dcnt <= dcnt+1.
  - A glitch that returns before DEB consecutive ticks is discarded.
  - Acceptance happens on the DEB-th tick after the change, i.e. DEB..DEB+1 frames after the pin change.
- Edges:
  - press/release are asserted the same clk the btn register changes; high exactly 1 clk.
  - press and release are never high together on the same bit.
- Long press, per bit, 8-bit counter hcnt:
  - Cleared while btn == 0.
  - On tick with btn == 1: increments, saturating at LONG.
  - long_press = btn && hcnt == LONG, registered.
  - Drops on the same clk as release.
- Bits are fully independent; simultaneous events on different bits are all reported in the same clk.
- Reset asserted mid-debounce or mid-hold discards all progress; no press/release pulse is generated at reset exit.

Optional Feature:
- Macro: JTFRAME_BTN_REPEAT_EN.
- Defined:
  - Each bit has a 4-bit repeat counter rcnt, active once long_press is high.
  - rpt pulses 1 clk on the tick where long_press first rises.
  - Thereafter rpt pulses every 8th tick while held; rcnt wraps 7->0.
  - rcnt is cleared on release.
  - rpt is never asserted in the same clk as press.
- Undefined: rpt is constant 0 and no repeat logic is synthesised.

Test Plan:
- Reset then idle, ACTIVE_LOW=1, btn_raw=2'b11, 10 ticks -> btn=0, press/release/long_press never asserted.
- DEB=3: btn_raw[0]=0 held -> press[0] is a single 1-clk pulse on the 3rd tick after sync changes; btn[0]=1 from that clk; bit 1 stays 0.
- Glitch: btn_raw[0] low for 2 ticks, then high -> no press, btn stays 0, dcnt back to 0.
- LONG=60: hold 70 frames -> long_press[0] rises on the 60th tick after press and holds; release -> long_press and btn drop the same clk as the release pulse.
- Both bits pressed in the same clk -> press=2'b11 on one clk; reset asserted at tick 2 of a debounce -> after reset exit, outputs stay 0 until 3 fresh stable ticks.
- JTFRAME_BTN_REPEAT_EN, LONG=10, hold 35 ticks -> rpt pulses at ticks 10, 18, 26, 34 after press; undefined build -> rpt=0 throughout.

Source files
------------

// File: rtl/jtframe_btn_sense_if.sv
// jtframe_btn_sense_if: button sense bus between board pins and game/framework logic
//   LVBL       vertical blank, active-low; its falling edge is the frame tick
//   btn_raw    raw asynchronous button pins
//   btn        debounced level, 1 = pressed
//   press      one-clk pulse on debounced 0->1
//   rel        one-clk pulse on debounced 1->0 ("release" is a reserved word)
//   long_press level, high while held for at least LONG frames
//   rpt        auto-repeat pulse (zero unless JTFRAME_BTN_REPEAT_EN)
interface jtframe_btn_sense_if #(parameter int N = 2);
    logic         LVBL;
    logic [N-1:0] btn_raw, btn, press, rel, long_press, rpt;
    modport master(output LVBL, btn_raw, input btn, press, rel, long_press, rpt);
    modport slave(input LVBL, btn_raw, output btn, press, rel, long_press, rpt);
endinterface

// File: rtl/jtframe_btn_sense.sv
// jtframe_btn_sense: per-button synchroniser, frame debouncer, edge and long-press detector
//   rst  asynchronous reset, active-high
//   clk  system clock
//   bus  jtframe_btn_sense_if slave: LVBL, btn_raw in; btn, press, rel, long_press, rpt out
// Optional macro JTFRAME_BTN_REPEAT_EN adds the auto-repeat pulse rpt; otherwise rpt is 0.
module jtframe_btn_sense #(
    parameter int N          = 2,
    parameter int DEB        = 3,
    parameter int LONG       = 60,
    parameter int ACTIVE_LOW = 1
)(
    input logic rst,
    input logic clk,
    jtframe_btn_sense_if.slave bus
);
    localparam logic       REL    = ACTIVE_LOW != 0;
    localparam logic [3:0] DEB_M1 = 4'(DEB - 1);
    localparam logic [7:0] LONG_C = 8'(LONG);
    logic [N-1:0] s0, s1, sync, btn, press, rel, long_press, btn_n, lp_n;
    logic         last_lvbl, tick;
    logic [3:0]   dcnt [N];
    logic [3:0]   dcnt_n [N];
    logic [7:0]   hcnt [N];
    logic [7:0]   hcnt_n [N];
    // flops hold raw pin levels, so the released level is REL; sync is 1 = pressed
    assign sync = s1 ^ {N{REL}};
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dcnt_n[i] = !tick ? dcnt[i] : (sync[i] == btn[i] || dcnt[i] == DEB_M1) ? 4'd0 : dcnt[i] + 4'd1;
            btn_n[i]  = (tick && sync[i] != btn[i] && dcnt[i] == DEB_M1) ? sync[i] : btn[i];
            // the tick that accepts a press does not count towards the hold time
            hcnt_n[i] = !btn_n[i] ? 8'd0 : (tick && btn[i] && hcnt[i] != LONG_C) ? hcnt[i] + 8'd1 : hcnt[i];
            lp_n[i]   = btn_n[i] && hcnt_n[i] == LONG_C;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0         <= {N{REL}};
            s1         <= {N{REL}};
            last_lvbl  <= 1'b0;
            tick       <= 1'b0;
            btn        <= '0;
            press      <= '0;
            rel        <= '0;
            long_press <= '0;
            for (int i = 0; i < N; i++) begin
                dcnt[i] <= 4'd0;
                hcnt[i] <= 8'd0;
            end
        end else begin
            s0         <= bus.btn_raw;
            s1         <= s0;
            last_lvbl  <= bus.LVBL;
            tick       <= !bus.LVBL && last_lvbl;
            btn        <= btn_n;
            press      <= btn_n & ~btn;
            rel        <= ~btn_n & btn;
            long_press <= lp_n;
            dcnt       <= dcnt_n;
            hcnt       <= hcnt_n;
        end
    end
    assign bus.btn        = btn;
    assign bus.press      = press;
    assign bus.rel        = rel;
    assign bus.long_press = long_press;
`ifdef JTFRAME_BTN_REPEAT_EN
    logic [3:0]   rcnt [N];
    logic [3:0]   rcnt_n [N];
    logic [N-1:0] rpt, rpt_n;
    // first pulse on the long-press rise, then one every 8 ticks as rcnt wraps 7->0
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rcnt_n[i] = !lp_n[i] ? 4'd0 : (tick && long_press[i]) ? (rcnt[i] == 4'd7 ? 4'd0 : rcnt[i] + 4'd1) : rcnt[i];
            rpt_n[i]  = lp_n[i] && (!long_press[i] || (tick && rcnt[i] == 4'd7));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt <= '0;
            for (int i = 0; i < N; i++) rcnt[i] <= 4'd0;
        end else begin
            rpt  <= rpt_n;
            rcnt <= rcnt_n;
        end
    end
    assign bus.rpt = rpt;
`else
    assign bus.rpt = '0;
`endif
endmodule

// File: tb/tb_jtframe_btn_sense.sv
// tb_jtframe_btn_sense: scoreboard bench for jtframe_btn_sense (default or JTFRAME_BTN_REPEAT_EN build)
module tb_jtframe_btn_sense;
    localparam int DEB  = 3;
`ifdef JTFRAME_BTN_REPEAT_EN
    localparam int LONG = 10;
`else
    localparam int LONG = 60;
`endif
    localparam int HOLD = 70;
    typedef struct {
        int         frame;
        logic [1:0] press, rel, lp, rpt;
        string      name;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, bad = 0, fcnt = 0, pf = 0;
    logic [1:0] lp_prev = 2'b00;
    ev_t  sb [$];
    ev_t  e;
    jtframe_btn_sense_if #(.N(2)) bus();
    jtframe_btn_sense #(.N(2), .DEB(DEB), .LONG(LONG), .ACTIVE_LOW(1)) dut (
        .rst(rst),
        .clk(clk),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // every output pulse or long_press change is an event that must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && ((bus.press | bus.rel | bus.rpt) != 2'b00 || bus.long_press != lp_prev)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected event: frame=%0d press=%b rel=%b lp=%b rpt=%b",
                         fcnt, bus.press, bus.rel, bus.long_press, bus.rpt);
            end else begin
                e = sb.pop_front();
                if (fcnt !== e.frame || bus.press !== e.press || bus.rel !== e.rel ||
                    bus.long_press !== e.lp || bus.rpt !== e.rpt) begin
                    bad++;
                    $display("FAIL %s: got frame=%0d press=%b rel=%b lp=%b rpt=%b, want frame=%0d press=%b rel=%b lp=%b rpt=%b",
                             e.name, fcnt, bus.press, bus.rel, bus.long_press, bus.rpt,
                             e.frame, e.press, e.rel, e.lp, e.rpt);
                end
            end
        end
        lp_prev = bus.long_press;
    end
    task automatic frames(input int n);
        repeat (n) begin
            bus.LVBL = 1'b1;
            repeat (6) @(negedge clk);
            bus.LVBL = 1'b0;
            fcnt++;
            repeat (6) @(negedge clk);
        end
    endtask
    task automatic push(input int f, input logic [1:0] p, input logic [1:0] r,
                        input logic [1:0] l, input logic [1:0] q, input string nm);
        ev_t x;
        x.frame = f; x.press = p; x.rel = r; x.lp = l; x.rpt = q; x.name = nm;
        sb.push_back(x);
    endtask
    task automatic test_reset;
        bus.LVBL = 1'b1;
        bus.btn_raw = 2'b11;
        repeat (4) @(negedge clk);
        total += 5;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL reset_btn: got %b want 00", bus.btn); end
        if (bus.press !== 2'b00) begin bad++; $display("FAIL reset_press: got %b want 00", bus.press); end
        if (bus.rel !== 2'b00) begin bad++; $display("FAIL reset_rel: got %b want 00", bus.rel); end
        if (bus.long_press !== 2'b00) begin bad++; $display("FAIL reset_lp: got %b want 00", bus.long_press); end
        if (bus.rpt !== 2'b00) begin bad++; $display("FAIL reset_rpt: got %b want 00", bus.rpt); end
        rst = 1'b0;
        frames(10);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL idle_btn: got %b want 00", bus.btn); end
    endtask
    task automatic test_press;
        bus.btn_raw = 2'b10;
        pf = fcnt + DEB;
        push(pf, 2'b01, 2'b00, 2'b00, 2'b00, "press0");
        frames(DEB - 1);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL press_early: got %b want 00", bus.btn); end
        frames(1);
        total++;
        if (bus.btn !== 2'b01) begin bad++; $display("FAIL press_btn: got %b want 01", bus.btn); end
    endtask
    task automatic test_long;
        int r;
        push(pf + LONG, 2'b00, 2'b00, 2'b01,
`ifdef JTFRAME_BTN_REPEAT_EN
             2'b01,
`else
             2'b00,
`endif
             "long_rise");
`ifdef JTFRAME_BTN_REPEAT_EN
        for (int t = LONG + 8; t < HOLD + DEB; t += 8)
            push(pf + t, 2'b00, 2'b00, 2'b01, 2'b01, "repeat");
`endif
        frames(pf + HOLD - fcnt);
        total++;
        if (bus.long_press !== 2'b01) begin bad++; $display("FAIL long_held: got %b want 01", bus.long_press); end
        bus.btn_raw = 2'b11;
        r = fcnt;
        push(r + DEB, 2'b00, 2'b01, 2'b00, 2'b00, "long_release");
        frames(DEB + 1);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL release_btn: got %b want 00", bus.btn); end
    endtask
    task automatic test_glitch;
        bus.btn_raw = 2'b10;
        frames(DEB - 1);
        bus.btn_raw = 2'b11;
        frames(1);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL glitch_btn: got %b want 00", bus.btn); end
        // a fresh press must again need the full DEB ticks
        bus.btn_raw = 2'b10;
        push(fcnt + DEB, 2'b01, 2'b00, 2'b00, 2'b00, "press_after_glitch");
        frames(DEB + 1);
        bus.btn_raw = 2'b11;
        push(fcnt + DEB, 2'b00, 2'b01, 2'b00, 2'b00, "release_after_glitch");
        frames(DEB + 1);
    endtask
    task automatic test_both;
        bus.btn_raw = 2'b00;
        push(fcnt + DEB, 2'b11, 2'b00, 2'b00, 2'b00, "press_both");
        frames(DEB + 1);
        total++;
        if (bus.btn !== 2'b11) begin bad++; $display("FAIL both_btn: got %b want 11", bus.btn); end
        bus.btn_raw = 2'b11;
        push(fcnt + DEB, 2'b00, 2'b11, 2'b00, 2'b00, "release_both");
        frames(DEB + 1);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL both_rel_btn: got %b want 00", bus.btn); end
    endtask
    task automatic test_reset_mid;
        int f;
        bus.btn_raw = 2'b01;
        frames(DEB - 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        f = fcnt;
        push(f + DEB, 2'b10, 2'b00, 2'b00, 2'b00, "press_after_reset");
        frames(DEB - 1);
        total++;
        if (bus.btn !== 2'b00) begin bad++; $display("FAIL reset_mid_btn: got %b want 00", bus.btn); end
        frames(2);
        total++;
        if (bus.btn !== 2'b10) begin bad++; $display("FAIL reset_mid_press: got %b want 10", bus.btn); end
        bus.btn_raw = 2'b11;
        push(fcnt + DEB, 2'b00, 2'b10, 2'b00, 2'b00, "release_after_reset");
        frames(DEB + 1);
    endtask
    initial begin
        test_reset;
        test_press;
        test_long;
        test_glitch;
        test_both;
        test_reset_mid;
        frames(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
